execute_stage: RTL and testbench
================================

// Module: execute_stage
// PURPOSE
//  Parametrised, registered EX pipeline stage between decode and memory. Selects ALU operands
//  (register or immediate), runs single-cycle ALU ops and an iterative multi-cycle multiply, and
//  keeps a condition-code register. Resolves branches/jumps, emitting target PC and one-cycle flush.
//  Stalls upstream while multiplying or while memory stage applies back-pressure.
// PARAMETERS
//  DATA_W   32  datapath width (bits); >=8
//  PC_W     16  program counter width
//  REG_AW    4  register address width
//  MUL_LAT   4  multiply latency in cycles, 2..DATA_W; product bits per step = ceil(DATA_W/MUL_LAT)
// PORTS
//  clk         in   1         clock, all state on rising edge
//  rst         in   1         synchronous, active-high reset
//  in_valid    in   1         decode presents an instruction
//  pc_in       in   PC_W      PC of incoming instruction
//  rq_rd       in   DATA_W    first register read data (operand A / store data)
//  rs          in   DATA_W    second register read data (operand B)
//  imm         in   DATA_W    sign-extended immediate
//  ra_addr     in   REG_AW    source address of rq_rd (forwarding)
//  rb_addr     in   REG_AW    source address of rs (forwarding)
//  rd_addr     in   REG_AW    destination register
//  alu_op      in   4         exec_pkg::alu_op_t (ADD,SUB,AND,OR,XOR,SHL,SHR,SRA,PASSB,MUL)
//  a_imm       in   1         1: operand A = imm
//  b_imm       in   1         1: operand B = imm
//  set_cc      in   1         update condition codes with this result
//  is_branch   in   1         conditional branch, condition = cond
//  is_jump     in   1         unconditional jump, target = operand A
//  cond        in   3         exec_pkg::cond_t (AL,EQ,NE,LT,GE,LTU,GEU,NV)
//  wr_en       in   1         instruction writes rd
//  mem_stall   in   1         downstream cannot accept output this cycle
//  stall_out   out  1         upstream must hold its outputs
//  out_valid   out  1         registered result valid
//  alu_out     out  DATA_W    registered result
//  store_data  out  DATA_W    registered rq_rd (post-forwarding)
//  rd_out      out  REG_AW    registered destination
//  wr_en_out   out  1         registered write enable (0 when out_valid=0)
//  pc_out      out  PC_W      branch/jump target, valid while flush=1
//  flush       out  1         one-cycle pulse: taken branch or jump
// BEHAVIOUR
//  - Reset: all outputs 0; CC {N,Z,C,V}=0; FSM=IDLE; multiplier cleared. Reset mid-multiply aborts it.
//  - Accept: in_valid && !stall_out && !flush. Non-MUL op: output registers load next edge (latency 1).
//  - Output hold: when mem_stall=1, all output registers hold; stall_out=1; nothing accepted.
//  - FSM IDLE->MUL on accepted MUL: latch operands, stall_out=1 for MUL_LAT-1 cycles; MUL->IDLE after
//    MUL_LAT cycles, low DATA_W product bits into alu_out with out_valid=1. In MUL, out_valid=0.
//  - Arithmetic: ADD/SUB modulo 2^DATA_W; C=carry-out (SUB: C=no-borrow), V=signed overflow;
//    shifts use operand B[log2(DATA_W)-1:0]; N=msb, Z=(result==0). CC updates only on accepted
//    set_cc; MUL sets N,Z, clears C,V.
//  - Branch uses CC as registered before this instruction (set_cc on the branch itself ignored).
//    Target = pc_in + imm[PC_W-1:0], wraps modulo 2^PC_W. Jump target = operand A[PC_W-1:0].
//  - Taken branch/jump: flush=1 and pc_out=target for exactly the cycle out_valid shows it; the
//    in_valid instruction present in the flush cycle is discarded (no CC update, no MUL start).
//  - Branch/jump with mem_stall: flush stays high until output advances, but counts as one event.
//  - Not-taken branch: out_valid=1, wr_en_out=0, flush=0.
// CONFIGURATION
//  EXEC_FORWARD_EN defined: if out_valid && wr_en_out && rd_out==ra_addr (resp. rb_addr), operand
//    uses alu_out instead of rq_rd (resp. rs); immediates never forwarded; rd_out==0 never forwards.
//  Undefined: ra_addr/rb_addr ignored; operands taken directly from inputs.
// STRUCTURE
//  exec_pkg: alu_op_t, cond_t, exec_state_t (IDLE,MUL), CC bit indices.
//  Sub-module exec_mul: iterative radix-2^k shift-add multiplier, start/busy/done, DATA_W/MUL_LAT params.
// TESTING
//  1. ADD rq_rd=7FFF_FFFF, imm=1, b_imm=1, set_cc -> alu_out=8000_0000, N=1,V=1,C=0,Z=0, 1-cycle.
//  2. MUL 0x1234*0x10, MUL_LAT=4 -> stall_out 3 cycles, then alu_out=0x12340, out_valid 1 cycle.
//  3. SUB 5-5 set_cc, then BEQ pc_in=FFF0 imm=0x20 -> flush 1 cycle, pc_out=0010; next in dropped.
//  4. mem_stall held 3 cycles over ADD result -> alu_out/out_valid stable, stall_out=1 throughout.
//  5. rst asserted in 2nd MUL cycle -> next cycle all outputs 0, FSM IDLE, new op accepted.
//  6. EXEC_FORWARD_EN: ADD r3=10, next ADD r4=r3+r3 -> alu_out=20; without macro uses stale rq_rd.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared types for the EX stage: ALU opcodes, branch conditions, FSM states, CC bit indices.
package exec_pkg;

    typedef enum logic [3:0] {
        OpAdd   = 4'd0,
        OpSub   = 4'd1,
        OpAnd   = 4'd2,
        OpOr    = 4'd3,
        OpXor   = 4'd4,
        OpShl   = 4'd5,
        OpShr   = 4'd6,
        OpSra   = 4'd7,
        OpPassB = 4'd8,
        OpMul   = 4'd9
    } alu_op_t;

    typedef enum logic [2:0] {
        CondAl, CondEq, CondNe, CondLt, CondGe, CondLtu, CondGeu, CondNv
    } cond_t;

    typedef enum logic [0:0] {
        StIdle,
        StMul
    } exec_state_t;

    // Condition-code register layout {N,Z,C,V}
    localparam int unsigned CcN = 3;
    localparam int unsigned CcZ = 2;
    localparam int unsigned CcC = 1;
    localparam int unsigned CcV = 0;

    function automatic logic cond_true(input cond_t c, input logic [3:0] cc);
        logic r;
        r = 1'b0;
        unique case (c)
            CondAl:  r = 1'b1;
            CondEq:  r = cc[CcZ];
            CondNe:  r = !cc[CcZ];
            CondLt:  r = cc[CcN] ^ cc[CcV];
            CondGe:  r = !(cc[CcN] ^ cc[CcV]);
            CondLtu: r = !cc[CcC];
            CondGeu: r = cc[CcC];
            CondNv:  r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/execute_stage_if.sv
// Decode-side instruction bundle and memory-side result bundle of the EX stage.
interface execute_stage_if
    import exec_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned PC_W   = 16,
    parameter int unsigned REG_AW = 4
) ();

    logic              in_valid;
    logic [PC_W-1:0]   pc_in;
    logic [DATA_W-1:0] rq_rd;
    logic [DATA_W-1:0] rs;
    logic [DATA_W-1:0] imm;
    logic [REG_AW-1:0] ra_addr;
    logic [REG_AW-1:0] rb_addr;
    logic [REG_AW-1:0] rd_addr;
    alu_op_t           alu_op;
    logic              a_imm;
    logic              b_imm;
    logic              set_cc;
    logic              is_branch;
    logic              is_jump;
    cond_t             cond;
    logic              wr_en;
    logic              mem_stall;
    logic              stall_out;
    logic              out_valid;
    logic [DATA_W-1:0] alu_out;
    logic [DATA_W-1:0] store_data;
    logic [REG_AW-1:0] rd_out;
    logic              wr_en_out;
    logic [PC_W-1:0]   pc_out;
    logic              flush;

    modport master (
        output in_valid, pc_in, rq_rd, rs, imm, ra_addr, rb_addr, rd_addr, alu_op, a_imm,
               b_imm, set_cc, is_branch, is_jump, cond, wr_en, mem_stall,
        input  stall_out, out_valid, alu_out, store_data, rd_out, wr_en_out, pc_out, flush
    );

    modport slave (
        input  in_valid, pc_in, rq_rd, rs, imm, ra_addr, rb_addr, rd_addr, alu_op, a_imm,
               b_imm, set_cc, is_branch, is_jump, cond, wr_en, mem_stall,
        output stall_out, out_valid, alu_out, store_data, rd_out, wr_en_out, pc_out, flush
    );

endinterface

// File: rtl/exec_mul.sv
// Iterative radix-2^K shift-add multiplier; digit 0 is folded in at start, the last digit
// is added combinationally so the product is ready in the cycle done is high.
module exec_mul #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MUL_LAT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              en,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] product
);

    localparam int unsigned K    = (DATA_W + MUL_LAT - 1) / MUL_LAT;
    localparam int unsigned CntW = $clog2(MUL_LAT) + 1;

    logic [DATA_W-1:0] a_q, b_q, acc_q, acc_d;
    logic [CntW-1:0]   cnt_q;
    logic              busy_q;

    function automatic logic [DATA_W-1:0] digit_mul(input logic [DATA_W-1:0] x,
                                                    input logic [K-1:0] d);
        logic [DATA_W-1:0] sum;
        sum = '0;
        for (int j = 0; j < int'(K); j++) begin
            if (d[j]) sum = sum + (x << j);
        end
        return sum;
    endfunction

    always_comb begin
        acc_d = acc_q + digit_mul(a_q, b_q[K-1:0]);
    end

    assign busy    = busy_q;
    assign done    = busy_q && (cnt_q == CntW'(MUL_LAT - 1));
    assign product = acc_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
        end else if (start) begin
            busy_q <= 1'b1;
            cnt_q  <= CntW'(1);
            acc_q  <= digit_mul(a, b[K-1:0]);
            a_q    <= a << K;
            b_q    <= b >> K;
        end else if (busy_q && en) begin
            acc_q <= acc_d;
            a_q   <= a_q << K;
            b_q   <= b_q >> K;
            cnt_q <= cnt_q + 1'b1;
            if (done) busy_q <= 1'b0;
        end
    end

endmodule

// File: rtl/execute_stage.sv
// Registered EX stage: operand select, ALU, iterative multiply, CC register, branch resolve.
// Define EXEC_FORWARD_EN to forward the registered result into operands A/B.
module execute_stage
    import exec_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned PC_W    = 16,
    parameter int unsigned REG_AW  = 4,
    parameter int unsigned MUL_LAT = 4
) (
    input logic            clk,
    input logic            rst,
    execute_stage_if.slave bus
);

    localparam int unsigned ShW = $clog2(DATA_W);

    exec_state_t       state_q, state_d;
    logic [3:0]        cc_q, cc_d;
    logic              out_valid_q, wr_en_out_q, flush_q;
    logic [DATA_W-1:0] alu_out_q, store_data_q;
    logic [REG_AW-1:0] rd_out_q;
    logic [PC_W-1:0]   pc_out_q;

    logic [REG_AW-1:0] mul_rd_q;
    logic              mul_wr_q, mul_cc_q;
    logic [DATA_W-1:0] mul_sd_q;

    logic              stall, accept, is_mul, taken, mul_start, mul_finish;
    logic              mul_busy, mul_done;
    logic [DATA_W-1:0] opa_raw, opb_raw, opa, opb, alu_res, mul_product;
    logic [PC_W-1:0]   target;
    logic              res_c, res_v;
    logic [ShW-1:0]    shamt;

    assign stall      = bus.mem_stall || (state_q == StMul);
    assign accept     = bus.in_valid && !stall && !flush_q;
    assign is_mul     = (bus.alu_op == OpMul);
    assign mul_start  = accept && is_mul;
    assign mul_finish = (state_q == StMul) && mul_busy && mul_done && !bus.mem_stall;

    always_comb begin
        opa_raw = bus.rq_rd;
        opb_raw = bus.rs;
`ifdef EXEC_FORWARD_EN
        if (out_valid_q && wr_en_out_q && (rd_out_q != '0)) begin
            if (rd_out_q == bus.ra_addr) opa_raw = alu_out_q;
            if (rd_out_q == bus.rb_addr) opb_raw = alu_out_q;
        end
`endif
        opa = bus.a_imm ? bus.imm : opa_raw;
        opb = bus.b_imm ? bus.imm : opb_raw;
    end

`ifndef EXEC_FORWARD_EN
    logic unused_fwd_addr;
    assign unused_fwd_addr = ^{bus.ra_addr, bus.rb_addr};
`endif

    assign shamt = opb[ShW-1:0];

    always_comb begin
        alu_res = '0;
        res_c   = 1'b0;
        res_v   = 1'b0;
        unique case (bus.alu_op)
            OpAdd: begin
                {res_c, alu_res} = {1'b0, opa} + {1'b0, opb};
                res_v = (opa[DATA_W-1] == opb[DATA_W-1]) && (alu_res[DATA_W-1] != opa[DATA_W-1]);
            end
            OpSub: begin
                // Carry out of a + ~b + 1 is the no-borrow flag
                {res_c, alu_res} = {1'b0, opa} + {1'b0, ~opb} + {{DATA_W{1'b0}}, 1'b1};
                res_v = (opa[DATA_W-1] != opb[DATA_W-1]) && (alu_res[DATA_W-1] != opa[DATA_W-1]);
            end
            OpAnd:   alu_res = opa & opb;
            OpOr:    alu_res = opa | opb;
            OpXor:   alu_res = opa ^ opb;
            OpShl:   alu_res = opa << shamt;
            OpShr:   alu_res = opa >> shamt;
            OpSra:   alu_res = $unsigned($signed(opa) >>> shamt);
            OpPassB: alu_res = opb;
            default: alu_res = '0;
        endcase
    end

    assign taken  = bus.is_jump || (bus.is_branch && cond_true(bus.cond, cc_q));
    assign target = bus.is_jump ? opa[PC_W-1:0] : (bus.pc_in + bus.imm[PC_W-1:0]);

    exec_mul #(
        .DATA_W (DATA_W),
        .MUL_LAT(MUL_LAT)
    ) u_mul (
        .clk    (clk),
        .rst    (rst),
        .start  (mul_start),
        .en     (!bus.mem_stall),
        .a      (opa),
        .b      (opb),
        .busy   (mul_busy),
        .done   (mul_done),
        .product(mul_product)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (mul_start) state_d = StMul;
            StMul:   if (mul_finish) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cc_d = cc_q;
        if (mul_finish && mul_cc_q) begin
            cc_d[CcN] = mul_product[DATA_W-1];
            cc_d[CcZ] = (mul_product == '0);
            cc_d[CcC] = 1'b0;
            cc_d[CcV] = 1'b0;
        end else if (accept && !is_mul && bus.set_cc && !bus.is_branch) begin
            cc_d[CcN] = alu_res[DATA_W-1];
            cc_d[CcZ] = (alu_res == '0);
            cc_d[CcC] = res_c;
            cc_d[CcV] = res_v;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cc_q    <= '0;
        end else begin
            state_q <= state_d;
            cc_q    <= cc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mul_rd_q <= '0;
            mul_wr_q <= 1'b0;
            mul_cc_q <= 1'b0;
            mul_sd_q <= '0;
        end else if (mul_start) begin
            mul_rd_q <= bus.rd_addr;
            mul_wr_q <= bus.wr_en;
            mul_cc_q <= bus.set_cc;
            mul_sd_q <= opa_raw;
        end
    end

    // Output registers advance only when memory accepts; otherwise everything holds
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            wr_en_out_q  <= 1'b0;
            flush_q      <= 1'b0;
            alu_out_q    <= '0;
            store_data_q <= '0;
            rd_out_q     <= '0;
            pc_out_q     <= '0;
        end else if (!bus.mem_stall) begin
            out_valid_q <= 1'b0;
            wr_en_out_q <= 1'b0;
            flush_q     <= 1'b0;
            if (mul_finish) begin
                out_valid_q  <= 1'b1;
                alu_out_q    <= mul_product;
                store_data_q <= mul_sd_q;
                rd_out_q     <= mul_rd_q;
                wr_en_out_q  <= mul_wr_q;
            end else if (accept && !is_mul) begin
                out_valid_q  <= 1'b1;
                alu_out_q    <= alu_res;
                store_data_q <= opa_raw;
                rd_out_q     <= bus.rd_addr;
                wr_en_out_q  <= bus.wr_en && !bus.is_branch;
                flush_q      <= taken;
                pc_out_q     <= taken ? target : '0;
            end
        end
    end

    assign bus.stall_out  = stall;
    assign bus.out_valid  = out_valid_q;
    assign bus.alu_out    = alu_out_q;
    assign bus.store_data = store_data_q;
    assign bus.rd_out     = rd_out_q;
    assign bus.wr_en_out  = wr_en_out_q;
    assign bus.pc_out     = pc_out_q;
    assign bus.flush      = flush_q;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage with an expected-result scoreboard.
module tb_execute_stage;
    import exec_pkg::*;

    typedef struct packed {
        logic [31:0] alu;
        logic        wr;
        logic [3:0]  rd;
        logic        fl;
        logic [15:0] pc;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n;
    exp_t sb[$];

    execute_stage_if #(.DATA_W(32), .PC_W(16), .REG_AW(4)) bus ();

    execute_stage #(
        .DATA_W (32),
        .PC_W   (16),
        .REG_AW (4),
        .MUL_LAT(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, required finish before timeout");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] alu, input logic wr, input logic [3:0] rd,
                        input logic fl, input logic [15:0] pc);
        exp_t e;
        e.alu = alu;
        e.wr  = wr;
        e.rd  = rd;
        e.fl  = fl;
        e.pc  = pc;
        sb.push_back(e);
    endtask

    // One clock: retire the head entry if memory took it, then check whatever is now shown
    task automatic tick();
        logic consumed;
        exp_t e;
        consumed = bus.out_valid && !bus.mem_stall;
        @(posedge clk);
        #1;
        if (consumed && sb.size() > 0) void'(sb.pop_front());
        if (bus.out_valid) begin
            if (sb.size() == 0) begin
                chk("spurious_out_valid", 64'(bus.out_valid), 64'd0);
            end else begin
                e = sb[0];
                chk("alu_out", 64'(bus.alu_out), 64'(e.alu));
                chk("wr_en_out", 64'(bus.wr_en_out), 64'(e.wr));
                chk("rd_out", 64'(bus.rd_out), 64'(e.rd));
                chk("flush", 64'(bus.flush), 64'(e.fl));
                if (e.fl) chk("pc_out", 64'(bus.pc_out), 64'(e.pc));
            end
        end
    endtask

    task automatic idle();
        bus.in_valid  = 1'b0;
        bus.pc_in     = '0;
        bus.rq_rd     = '0;
        bus.rs        = '0;
        bus.imm       = '0;
        bus.ra_addr   = '0;
        bus.rb_addr   = '0;
        bus.rd_addr   = '0;
        bus.alu_op    = OpAdd;
        bus.a_imm     = 1'b0;
        bus.b_imm     = 1'b0;
        bus.set_cc    = 1'b0;
        bus.is_branch = 1'b0;
        bus.is_jump   = 1'b0;
        bus.cond      = CondAl;
        bus.wr_en     = 1'b0;
        bus.mem_stall = 1'b0;
    endtask

    task automatic alu(input alu_op_t op, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] rd);
        idle();
        bus.in_valid = 1'b1;
        bus.alu_op   = op;
        bus.rq_rd    = a;
        bus.rs       = b;
        bus.rd_addr  = rd;
        bus.wr_en    = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        chk({tag, "_alu_out"}, 64'(bus.alu_out), 64'd0);
        chk({tag, "_store_data"}, 64'(bus.store_data), 64'd0);
        chk({tag, "_wr_en_out"}, 64'(bus.wr_en_out), 64'd0);
        chk({tag, "_flush"}, 64'(bus.flush), 64'd0);
        chk({tag, "_pc_out"}, 64'(bus.pc_out), 64'd0);
        chk({tag, "_stall_out"}, 64'(bus.stall_out), 64'd0);
        chk({tag, "_cc"}, 64'(dut.cc_q), 64'd0);
        chk({tag, "_fsm"}, 64'(dut.state_q), 64'(StIdle));
    endtask

    initial begin
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_all_zero("reset");

        // ADD overflow into the sign bit
        alu(OpAdd, 32'h7FFF_FFFF, 32'h0, 4'd1);
        bus.imm    = 32'd1;
        bus.b_imm  = 1'b1;
        bus.set_cc = 1'b1;
        push(32'h8000_0000, 1'b1, 4'd1, 1'b0, 16'h0);
        tick();
        chk("add_out_valid", 64'(bus.out_valid), 64'd1);
        chk("add_cc", 64'(dut.cc_q), 64'b1001);

        // SUB with borrow: C=0, N=1
        alu(OpSub, 32'd3, 32'd5, 4'd2);
        bus.set_cc = 1'b1;
        push(32'hFFFF_FFFE, 1'b1, 4'd2, 1'b0, 16'h0);
        tick();
        chk("sub_borrow_cc", 64'(dut.cc_q), 64'b1000);

        // Shifts use only the low log2(DATA_W) bits of operand B
        alu(OpShl, 32'd1, 32'h24, 4'd3);
        push(32'h10, 1'b1, 4'd3, 1'b0, 16'h0);
        tick();
        alu(OpShr, 32'h8000_0000, 32'd4, 4'd3);
        push(32'h0800_0000, 1'b1, 4'd3, 1'b0, 16'h0);
        tick();
        alu(OpSra, 32'h8000_0000, 32'd4, 4'd3);
        push(32'hF800_0000, 1'b1, 4'd3, 1'b0, 16'h0);
        tick();
        idle();
        tick();
        chk("idle_out_valid", 64'(bus.out_valid), 64'd0);

        // MUL: 3 stall cycles, next instruction held upstream until done
        alu(OpMul, 32'h1234, 32'h10, 4'd2);
        push(32'h0001_2340, 1'b1, 4'd2, 1'b0, 16'h0);
        tick();
        chk("mul_busy_out_valid", 64'(bus.out_valid), 64'd0);
        alu(OpAdd, 32'd3, 32'd4, 4'd3);
        push(32'd7, 1'b1, 4'd3, 1'b0, 16'h0);
        n = 0;
        while (bus.stall_out && n < 20) begin
            n++;
            tick();
        end
        chk("mul_stall_cycles", 64'(n), 64'd3);
        chk("mul_out_valid", 64'(bus.out_valid), 64'd1);
        tick();
        idle();
        tick();

        // SUB sets Z, BEQ wraps target, next instruction dropped
        alu(OpSub, 32'd5, 32'd5, 4'd4);
        bus.set_cc = 1'b1;
        push(32'd0, 1'b1, 4'd4, 1'b0, 16'h0);
        tick();
        chk("sub_zero_cc", 64'(dut.cc_q), 64'b0110);
        idle();
        bus.in_valid  = 1'b1;
        bus.is_branch = 1'b1;
        bus.cond      = CondEq;
        bus.pc_in     = 16'hFFF0;
        bus.imm       = 32'h20;
        push(32'd0, 1'b0, 4'd0, 1'b1, 16'h0010);
        tick();
        chk("beq_flush", 64'(bus.flush), 64'd1);
        alu(OpAdd, 32'd1, 32'd1, 4'd5);
        bus.set_cc = 1'b1;
        tick();
        chk("dropped_out_valid", 64'(bus.out_valid), 64'd0);
        chk("flush_one_cycle", 64'(bus.flush), 64'd0);
        chk("dropped_cc", 64'(dut.cc_q), 64'b0110);

        // Not-taken BNE with wr_en set must not write
        idle();
        bus.in_valid  = 1'b1;
        bus.is_branch = 1'b1;
        bus.cond      = CondNe;
        bus.pc_in     = 16'h0100;
        bus.imm       = 32'd4;
        bus.wr_en     = 1'b1;
        push(32'd0, 1'b0, 4'd0, 1'b0, 16'h0);
        tick();
        chk("bne_out_valid", 64'(bus.out_valid), 64'd1);

        // Jump target from operand A, result still written
        alu(OpPassB, 32'h1234_ABCD, 32'h55, 4'd1);
        bus.is_jump = 1'b1;
        push(32'h55, 1'b1, 4'd1, 1'b1, 16'hABCD);
        tick();
        idle();
        tick();
        chk("jump_flush_done", 64'(bus.flush), 64'd0);

        // mem_stall freezes the output for 3 cycles
        alu(OpAdd, 32'd2, 32'd3, 4'd6);
        push(32'd5, 1'b1, 4'd6, 1'b0, 16'h0);
        tick();
        alu(OpAdd, 32'd10, 32'd20, 4'd7);
        bus.mem_stall = 1'b1;
        push(32'd30, 1'b1, 4'd7, 1'b0, 16'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_stall_out", 64'(bus.stall_out), 64'd1);
            chk("hold_out_valid", 64'(bus.out_valid), 64'd1);
            chk("hold_alu_out", 64'(bus.alu_out), 64'd5);
        end
        bus.mem_stall = 1'b0;
        tick();
        idle();
        tick();

        // Reset in the second MUL cycle aborts the multiply
        alu(OpMul, 32'd6, 32'd7, 4'd8);
        tick();
        idle();
        tick();
        rst = 1'b1;
        sb.delete();
        tick();
        rst = 1'b0;
        check_all_zero("mul_reset");
        alu(OpAdd, 32'd1, 32'd1, 4'd9);
        push(32'd2, 1'b1, 4'd9, 1'b0, 16'h0);
        tick();
        chk("post_reset_accept", 64'(bus.out_valid), 64'd1);
        idle();
        for (int i = 0; i < 5; i++) tick();

        // Back-to-back dependency on r3
        alu(OpAdd, 32'd4, 32'd0, 4'd3);
        bus.imm   = 32'd6;
        bus.b_imm = 1'b1;
        push(32'd10, 1'b1, 4'd3, 1'b0, 16'h0);
        tick();
        alu(OpAdd, 32'd1, 32'd1, 4'd4);
        bus.ra_addr = 4'd3;
        bus.rb_addr = 4'd3;
`ifdef EXEC_FORWARD_EN
        push(32'd20, 1'b1, 4'd4, 1'b0, 16'h0);
`else
        push(32'd2, 1'b1, 4'd4, 1'b0, 16'h0);
`endif
        tick();
        idle();
        tick();

        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
